// File: rtl/cpu_control_unit.sv
// cpu_control_unit: instruction sequencer and decoder for the 8-bit CPU.
// Fetches instruction bytes, decodes them, drives the ALU opcode and the
// register-file strobes, keeps the PC, and tracks the Z/C/V flags used by the
// conditional jumps.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   mem_addr/mem_req         fetch address and request (held until mem_ack)
//   mem_ack/mem_rdata        fetch acknowledge and the byte valid with it
//   alu_op                   ADD=0 SUB=1 AND=2 OR=3 XOR=4
//   alu_result/cout/overflow ALU status, sampled for the flags in EXEC
//   rf_ra/rf_rb/rf_wa        register-file addresses (rd, rs, rd)
//   rf_we/rf_wsel/imm        write strobe, write source (0 ALU, 1 imm), LDI byte
//   flag_z/flag_c/flag_v     condition flags
//   halted/illegal           HALT state indicator, undefined-opcode pulse
module cpu_control_unit #(
    parameter logic [7:0] RESET_PC     = 8'h00,
    parameter bit         ILLEGAL_HALT = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [7:0] mem_addr,
    output logic       mem_req,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_cout,
    input  logic       alu_overflow,
    output logic [1:0] rf_ra,
    output logic [1:0] rf_rb,
    output logic [1:0] rf_wa,
    output logic       rf_we,
    output logic       rf_wsel,
    output logic [7:0] imm,
    output logic       flag_z,
    output logic       flag_c,
    output logic       flag_v,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_OPERAND,
        S_HALT
    } state_t;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] ir;
    logic [3:0] op;
    logic [3:0] op_m1;

    assign op    = ir[7:4];
    assign op_m1 = op - 4'd1;

    assign rf_ra    = ir[3:2];
    assign rf_rb    = ir[1:0];
    assign rf_wa    = ir[3:2];
    assign mem_addr = pc;

    // The request is decoded from the state and gated by rst so it drops the
    // instant reset is applied and is already up in the first cycle after it.
    assign mem_req = ((state == S_FETCH) || (state == S_OPERAND)) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            pc      <= RESET_PC;
            ir      <= '0;
            alu_op  <= '0;
            rf_we   <= 1'b0;
            rf_wsel <= 1'b0;
            imm     <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            halted  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-armed below.
            alu_op  <= '0;
            rf_we   <= 1'b0;
            rf_wsel <= 1'b0;
            illegal <= 1'b0;

            case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir    <= mem_rdata;
                        pc    <= pc + 8'd1;
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    case (op)
                        4'h0: state <= S_FETCH;
                        4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
                            // Outputs for EXEC are armed here so they are
                            // registered and valid for the whole EXEC cycle.
                            alu_op <= op_m1[2:0];
                            rf_we  <= 1'b1;
                            state  <= S_EXEC;
                        end
                        4'h6, 4'h7, 4'h8, 4'h9: state <= S_OPERAND;
                        4'hA: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            illegal <= 1'b1;
                            if (ILLEGAL_HALT) begin
                                halted <= 1'b1;
                                state  <= S_HALT;
                            end else begin
                                state <= S_FETCH;
                            end
                        end
                    endcase
                end

                // EXEC doubles as the LDI write cycle; flags only move for ALU ops.
                S_EXEC: begin
                    if (op != 4'h6) begin
                        flag_z <= (alu_result == 8'h00);
                        if ((op == 4'h1) || (op == 4'h2)) begin
                            flag_c <= alu_cout;
                            flag_v <= alu_overflow;
                        end else begin
                            flag_c <= 1'b0;
                            flag_v <= 1'b0;
                        end
                    end
                    state <= S_FETCH;
                end

                S_OPERAND: begin
                    if (mem_ack) begin
                        case (op)
                            4'h6: begin
                                imm     <= mem_rdata;
                                rf_we   <= 1'b1;
                                rf_wsel <= 1'b1;
                                pc      <= pc + 8'd1;
                                state   <= S_EXEC;
                            end
                            4'h7: begin
                                pc    <= mem_rdata;
                                state <= S_FETCH;
                            end
                            4'h8: begin
                                pc    <= flag_z ? mem_rdata : pc + 8'd1;
                                state <= S_FETCH;
                            end
                            4'h9: begin
                                pc    <= flag_c ? mem_rdata : pc + 8'd1;
                                state <= S_FETCH;
                            end
                            default: state <= S_FETCH;
                        endcase
                    end
                end

                S_HALT: begin
                    halted <= 1'b1;
                    state  <= S_HALT;
                end

                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Instruction sequencer and decoder for the 8-bit CPU. It is the producer side of the ALU interface: it fetches instruction bytes from memory, decodes them, and drives alu_op, the register-file select and write strobes, and the PC.
- It also consumes the ALU status outputs to maintain the Z/C/V flags that the conditional jumps use.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset.
- ILLEGAL_HALT, 0, 1 = an illegal opcode halts the core; 0 = it executes as NOP.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  8  fetch address.
- mem_req  out  1  fetch request.
- mem_ack  in  1  fetch acknowledge; mem_rdata is valid in the cycle mem_ack is high.
- mem_rdata  in  8  fetched byte.
- alu_op  out  3  encoding ADD=0, SUB=1, AND=2, OR=3, XOR=4.
- alu_result  in  8  ALU result, used to compute Z.
- alu_cout  in  1  ALU carry out.
- alu_overflow  in  1  ALU signed overflow.
- rf_ra  out  2  register-file read port A = IR[3:2] (rd).
- rf_rb  out  2  register-file read port B = IR[1:0] (rs).
- rf_wa  out  2  write address = IR[3:2].
- rf_we  out  1  register-file write strobe, 1 cycle.
- rf_wsel  out  1  write source: 0 = ALU result, 1 = imm.
- imm  out  8  immediate for LDI.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry flag.
- flag_v  out  1  overflow flag.
- halted  out  1  high while in HALT.
- illegal  out  1  1-cycle pulse on an undefined opcode.

Behaviour:
- Instruction format is IR[7:4]=op, IR[3:2]=rd, IR[1:0]=rs.
- Opcodes:
  - 0 = NOP.
  - 1..5 = ADD/SUB/AND/OR/XOR (rd <= rd op rs).
  - 6 = LDI rd, #byte.
  - 7 = JMP addr.
  - 8 = JZ addr.
  - 9 = JC addr.
  - A = HLT.
  - B..F = illegal.
- LDI, JMP, JZ and JC are two bytes; the second byte is fetched at PC after the opcode byte.
- Reset (async, immediate):
  - PC=RESET_PC, IR=0, state=FETCH.
  - Z/C/V=0.
  - mem_req=0, rf_we=0, alu_op=0, imm=0, halted=0, illegal=0.
  - Any pending fetch is abandoned. After reset deasserts, the first cycle asserts mem_req with mem_addr=RESET_PC.
- FSM states: FETCH, DECODE, EXEC, OPERAND, HALT.
- FETCH:
  - mem_req=1 and mem_addr=PC, both held stable until mem_ack is sampled high.
  - mem_ack may arrive in the same cycle as mem_req (zero wait) or any later cycle.
  - On ack: IR<=mem_rdata, PC<=PC+1, go to DECODE, and mem_req drops the next cycle.
- DECODE (1 cycle):
  - ALU op -> EXEC.
  - LDI/JMP/JZ/JC -> OPERAND.
  - HLT -> HALT.
  - NOP -> FETCH.
  - Illegal: pulse illegal; go to HALT if ILLEGAL_HALT=1, else FETCH.
- EXEC (1 cycle):
  - alu_op = op-1, rf_wsel=0, rf_we=1.
  - Flags update at the end of the cycle:
    - Z = (alu_result==0).
    - ADD/SUB: C = alu_cout, V = alu_overflow.
    - AND/OR/XOR: C=0, V=0.
  - Next state FETCH.
- OPERAND:
  - Same handshake as FETCH, with mem_addr=PC.
  - On ack, LDI: imm<=mem_rdata; rf_wsel=1 and rf_we=1 in the following cycle; PC<=PC+1; flags untouched.
  - On ack, JMP: PC<=mem_rdata.
  - On ack, JZ/JC: PC<=mem_rdata if flag_z/flag_c is 1, else PC<=PC+1.
  - Next state FETCH. LDI passes through one write cycle before FETCH.
- HALT: halted=1 and mem_req=0 indefinitely; only rst exits.
- Outside EXEC: alu_op=0 and rf_we=0, except the LDI write cycle.
- PC arithmetic is modulo 256: PC+1 from 8'hFF is 8'h00. An operand at 0xFF wraps the next fetch to 0x00.
- Cycle counts with zero-wait memory:
  - ALU op = 3 cycles (FETCH, DECODE, EXEC).
  - NOP = 2 cycles.
  - JMP/JZ/JC = 3 cycles.
  - LDI = 4 cycles.
- Flags change only in EXEC. A JZ/JC immediately after an ALU op sees that op's flags.
- mem_ack while mem_req=0 is ignored.

Test Plan:
- Reset release, memory {0x00:0x61, 0x01:0x2A, 0x02:0xA0}, zero-wait -> rf_we pulses with rf_wa=0, rf_wsel=1, imm=0x2A; halted=1 from cycle 6 on; mem_req never asserts afterward.
- ADD r0,r1 (0x11), alu_result=0x00, alu_cout=1, alu_overflow=0 -> in EXEC: alu_op=0, rf_we=1; afterwards Z=1, C=1, V=0. Then AND (0x31) with result 0x05 -> Z=0, C=0, V=0.
- JZ 0x40 with Z=1 -> next fetch mem_addr=0x40. With Z=0 at PC 0x10 -> next fetch mem_addr=0x12.
- Wait states: hold mem_ack low for 3 cycles during FETCH -> mem_req and mem_addr are stable the whole time, IR and PC are unchanged until ack, and there are no rf_we pulses.
- JMP opcode at 0xFE with operand at 0xFF=0x05; separately, NOP at 0xFF -> next fetch at 0x05; NOP at 0xFF wraps and fetches 0x00.
- Illegal opcode 0xC0 -> illegal is high for exactly 1 cycle; ILLEGAL_HALT=0: fetch continues at PC+1; ILLEGAL_HALT=1: halted=1. Assert rst mid-OPERAND wait -> mem_req=0 immediately, and the first post-reset fetch is at RESET_PC.
